// File: rtl/if_stage_pkg.sv
// Shared constants and bus types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
  localparam int          IF_TO_ID_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_PEND
  } npc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// IF-stage signal bundle: instruction SRAM port, IF->ID handshake and ID branch feedback.
interface if_stage_if;

  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    input  id_allowin, br_taken, br_target, inst_sram_rdata,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output if_to_id_valid, if_pc, if_inst
  );

  modport slave (
    output id_allowin, br_taken, br_target, inst_sram_rdata,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  if_to_id_valid, if_pc, if_inst
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, fetch PC register, 1-cycle SRAM fetch
// and a one-entry buffer that holds the fetched word while ID is stalled.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  if_stage_if.master   bus
);

  logic [31:0] pc_r;
  logic        if_valid;
  logic        br_pend;
  logic [31:0] br_tgt_r;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic                       if_ready_go;
  logic                       if_allowin;
  logic                       redirect;
  logic [31:0]                nextpc;
  logic [31:0]                inst_word;
  npc_sel_e                   npc_sel;
  logic [BR_BUS_WD-1:0]       br_bus;
  br_bus_t                    br;
  logic [IF_TO_ID_BUS_WD-1:0] to_id_bus;

  assign br_bus = {bus.br_taken, bus.br_target};
  assign br     = br_bus;

  assign if_ready_go = 1'b1;
  assign if_allowin  = ~if_valid | bus.id_allowin;
  assign redirect    = br.taken | br_pend;

  // A fresh redirect from ID beats a remembered one; otherwise fall through sequentially.
  always_comb begin
    npc_sel = NPC_SEQ;
    nextpc  = pc_r + 32'd4;
    if (redirect) begin
      npc_sel = br.taken ? NPC_BR : NPC_PEND;
    end
    case (npc_sel)
      NPC_BR:   nextpc = br.target;
      NPC_PEND: nextpc = br_tgt_r;
      default:  nextpc = pc_r + 32'd4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r      <= RESET_PC - 32'd4;
      if_valid  <= 1'b0;
      br_pend   <= 1'b0;
      br_tgt_r  <= 32'b0;
      buf_valid <= 1'b0;
      inst_buf  <= 32'b0;
    end else if (if_allowin) begin
      pc_r      <= nextpc;
      if_valid  <= 1'b1;
      br_pend   <= 1'b0;
      buf_valid <= 1'b0;
    end else if (br.taken) begin
      // Stalled IF cannot take the target now: kill the wrong-path word and remember where to go.
      br_pend   <= 1'b1;
      br_tgt_r  <= br.target;
      if_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (!buf_valid) begin
      inst_buf  <= bus.inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

  assign inst_word = reset ? 32'b0 : (buf_valid ? inst_buf : bus.inst_sram_rdata);
  assign to_id_bus = {pc_r, inst_word};

  assign bus.inst_sram_en    = if_allowin & ~reset;
  assign bus.inst_sram_we    = 4'b0;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'b0;

  assign bus.if_to_id_valid = if_valid & if_ready_go & ~br.taken;
  assign bus.if_pc          = to_id_bus[IF_TO_ID_BUS_WD-1:32];
  assign bus.if_inst        = to_id_bus[31:0];

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage LoongArch32 pipeline, directly upstream of `id_stage`. It holds the pre-IF next-PC logic and the fetch PC register, and it drives the synchronous instruction SRAM, which has 1-cycle read latency. It delivers `{pc, inst}` to ID with a valid/allowin handshake and absorbs branch redirects resolved in ID. A one-entry instruction buffer holds SRAM read data across ID stalls.

## Interface
- `RESET_PC`, default 32'h1c00_0000: address of the first instruction fetched after reset.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_allowin`  in  1  ID can accept an instruction this cycle.
- `br_taken`  in  1  ID resolved a taken branch/jump this cycle (single-cycle pulse).
- `br_target`  in  32  redirect address, valid when `br_taken`.
- `inst_sram_en`  out  1  read request.
- `inst_sram_we`  out  4  tied 4'b0.
- `inst_sram_addr`  out  32  fetch address (= nextpc).
- `inst_sram_wdata`  out  32  tied 32'b0.
- `inst_sram_rdata`  in  32  read data, valid one cycle after the request.
- `if_to_id_valid`  out  1  `{if_pc, if_inst}` is valid for ID.
- `if_pc`  out  32  PC of the instruction in IF.
- `if_inst`  out  32  instruction word in IF.

## Operation
- State registers: `pc_r` (32), `if_valid` (1), `br_pend` (1), `br_tgt_r` (32), `buf_valid` (1), `inst_buf` (32).
- Reset values:
  - `pc_r = RESET_PC - 4`; all other registers are 0.
  - Outputs during reset: `inst_sram_en = 0`, `if_to_id_valid = 0`, `if_pc = RESET_PC - 4`, `if_inst = 0`.
- Control signals:
  - `if_ready_go = 1`.
  - `if_allowin = ~if_valid | id_allowin`.
  - `inst_sram_en = if_allowin & ~reset`.
- `redirect = br_taken | br_pend`.
- `nextpc` selection, in priority order:
  - `br_taken` → `br_target`
  - else `br_pend` → `br_tgt_r`
  - else `pc_r + 4`, wrapping modulo 2^32.
- `if_to_id_valid = if_valid & ~br_taken`. The instruction in IF is on the wrong path whenever ID redirects, because there is no delay slot.
- `if_inst = buf_valid ? inst_buf : inst_sram_rdata`. `if_pc = pc_r`.
- On each clock edge when `if_allowin`:
  - `pc_r <= nextpc`, `if_valid <= 1`, `br_pend <= 0`, `buf_valid <= 0`.
- On each clock edge when `~if_allowin`:
  - If `br_taken`: `br_pend <= 1`, `br_tgt_r <= br_target`, `if_valid <= 0`, `buf_valid <= 0`.
  - Otherwise, if `~buf_valid`: `inst_buf <= inst_sram_rdata`, `buf_valid <= 1`.
- Boundary conditions:
  - `br_taken` together with `br_pend`: `br_taken` wins, and its target overwrites the pending one.
  - A stall lasting multiple cycles does not re-issue the SRAM request. The buffer keeps the first-cycle rdata; later rdata is ignored.
  - Reset asserted mid-operation: all state clears immediately and asynchronously, and any in-flight fetch is discarded.
  - Misaligned `br_target` is forwarded unchanged. Alignment exceptions are not handled in this block.

## Timing
- Cycle 0 is the first edge after reset deasserts.
  - Before edge 0: `inst_sram_en = 1`, `inst_sram_addr = RESET_PC`.
  - After edge 0: `if_valid = 1`, `if_pc = RESET_PC`, `if_inst = rdata`.
- Throughput is 1 instruction/cycle with no stall.
- Redirect latency:
  - `br_taken` in cycle t with `if_allowin` = 1: the target is requested in cycle t and is valid in IF at t+1.
  - If `if_allowin` = 0 in cycle t: the request goes out at t+1 and the target is valid in IF at t+2.
- Stall: while `id_allowin = 0` and `if_valid = 1`, `if_pc` and `if_inst` hold stable, and `inst_sram_en = 0`.

## Structure
- Shared package/header holds:
  - `RESET_PC`.
  - Bus width constants: `IF_TO_ID_BUS_WD = 64`, `BR_BUS_WD = 33` (`{br_taken, br_target}`).
- No sub-module; the instruction buffer is inline (about 150 lines of RTL).
- Synchronous SRAM model for the bench comes from the existing environment.

## Test plan
- Reset release, SRAM `mem[i] = i`, `id_allowin = 1` → fetch addresses 1c000000, 1c000004, 1c000008…; `if_to_id_valid` rises at cycle 0; `if_inst` tracks the stored words.
- `id_allowin = 0` for 3 cycles while `if_pc = 1c000008` → `if_pc`/`if_inst` stay stable, `inst_sram_en = 0`, and the buffered word is delivered when `id_allowin` returns; the next PC is 1c00000c.
- `br_taken`, target 1c000100, while `if_pc = 1c000010`, `id_allowin = 1` → `if_to_id_valid = 0` that cycle; next cycle `if_pc = 1c000100` and valid.
- `br_taken` (target 1c000200) while the IF stage is stalled → `br_pend` set and `if_valid` cleared; fetch of 1c000200 is issued the next cycle; 1c000010+4 is never delivered.
- Back-to-back `br_taken` (1c000300 then 1c000400) → only 1c000400 reaches ID as valid after the second pulse.
- Reset pulse mid-stream with buffer full → `if_to_id_valid = 0` at once; refetch starts at 1c000000.
